servo_pwm_gen: RTL and testbench



---
 rtl/servo_pwm_gen.sv | 152 +++++++++++++++
 tb/tb_servo_pwm_gen.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_gen.sv
// Servo PWM output stage: centre + signed sample, clamped, double-buffered to the period boundary.
// Latency: a sample becomes active at the first period start after it is latched (worst case PERIOD cycles).
// No backpressure: the newest sample overwrites any pending one; u_ack marks the period that adopts it.
module servo_pwm_gen #(
    parameter int N         = 19,
    parameter int CW        = 20,
    parameter int PERIOD    = 1000000,
    parameter int CENTER    = 75000,
    parameter int MIN_PULSE = 50000,
    parameter int MAX_PULSE = 100000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic signed [N-1:0] u_k,
    input  logic                u_valid,
    output logic                pwm_out,
    output logic                period_start,
    output logic                u_ack,
    output logic                sat_flag,
    output logic [CW-1:0]       active_width
);

    // Two guard bits above the wider operand keep CENTER + u_k free of overflow.
    localparam int SW = ((N > CW) ? N : CW) + 2;
    localparam logic signed [SW-1:0] MIN_S = SW'(MIN_PULSE);
    localparam logic signed [SW-1:0] MAX_S = SW'(MAX_PULSE);
    localparam logic signed [SW-1:0] CEN_S = SW'(CENTER);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [CW-1:0]         cnt;
    logic [CW-1:0]         cnt_nxt;
    logic                  load;

    logic signed [SW-1:0]  u_ext;
    logic signed [SW-1:0]  sum;
    logic [CW-1:0]         clamp_w;
    logic                  clamp_sat;

    logic [CW-1:0]         pending_w;
    logic                  pending_sat;
    logic                  new_flag;

    // Width arithmetic: centre plus sign-extended sample, clamped to the mechanical limits.
    always_comb begin
        u_ext     = {{(SW-N){u_k[N-1]}}, u_k};
        sum       = CEN_S + u_ext;
        clamp_w   = sum[CW-1:0];
        clamp_sat = 1'b0;
        if (sum < MIN_S) begin
            clamp_w   = CW'(MIN_PULSE);
            clamp_sat = 1'b1;
        end else if (sum > MAX_S) begin
            clamp_w   = CW'(MAX_PULSE);
            clamp_sat = 1'b1;
        end
    end

    // Pending buffer: last sample wins; the flag survives a load that coincides with a new sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_w   <= CW'(CENTER);
            pending_sat <= 1'b0;
            new_flag    <= 1'b0;
        end else begin
            if (u_valid) begin
                pending_w   <= clamp_w;
                pending_sat <= clamp_sat;
                new_flag    <= 1'b1;
            end else if (load) begin
                new_flag    <= 1'b0;
            end
        end
    end

    // Period FSM next-state: en is only looked at in IDLE and at the last cycle of a period.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load      = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (en) begin
                    state_nxt = HIGH;
                    load      = 1'b1;
                end
            end
            HIGH: begin
                cnt_nxt = cnt + CW'(1);
                if (cnt == active_width - CW'(1)) begin
                    state_nxt = LOW;
                end
            end
            LOW: begin
                if (cnt == CW'(PERIOD - 1)) begin
                    cnt_nxt = '0;
                    if (en) begin
                        state_nxt = HIGH;
                        load      = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Registered outputs; the load edge also publishes the width that the new period will use.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_out      <= 1'b0;
            period_start <= 1'b0;
            u_ack        <= 1'b0;
            sat_flag     <= 1'b0;
            active_width <= CW'(CENTER);
        end else begin
            pwm_out      <= (state_nxt == HIGH);
            period_start <= load;
            u_ack        <= load & new_flag;
            if (load) begin
                active_width <= pending_w;
                sat_flag     <= pending_sat;
            end
        end
    end

endmodule

// File: tb/tb_servo_pwm_gen.sv
module tb_servo_pwm_gen;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              u_valid;
    logic signed [7:0] u_k;
    logic              pwm_out;
    logic              period_start;
    logic              u_ack;
    logic              sat_flag;
    logic [7:0]        active_width;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int uk;
        int w;
        int sat;
    } vec_t;

    vec_t tbl[9];

    always #5 clk = ~clk;

    servo_pwm_gen #(
        .N(8), .CW(8), .PERIOD(100), .CENTER(8), .MIN_PULSE(5), .MAX_PULSE(11)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .u_k          (u_k),
        .u_valid      (u_valid),
        .pwm_out      (pwm_out),
        .period_start (period_start),
        .u_ack        (u_ack),
        .sat_flag     (sat_flag),
        .active_width (active_width)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Runs from a first-HIGH cycle up to the next period_start (bounded), optionally
    // strobing up to three samples at given offsets within the period.
    task automatic run_period(input int a0, input int v0, input int a1, input int v1,
                              input int a2, input int v2,
                              output int hi, output int len, output int acks);
        hi = 0;
        len = 0;
        acks = 0;
        do begin
            if (pwm_out) hi++;
            if (u_ack && len != 0) acks++;
            u_valid = 1'b0;
            if (len == a0) begin u_valid = 1'b1; u_k = 8'(v0); end
            if (len == a1) begin u_valid = 1'b1; u_k = 8'(v1); end
            if (len == a2) begin u_valid = 1'b1; u_k = 8'(v2); end
            len++;
            tick();
        end while (!period_start && len < 300);
        u_valid = 1'b0;
    endtask

    initial begin
        int hi, len, acks, cur_w, ps_cnt, hi2;

        tbl[0] = '{2, 10, 0};
        tbl[1] = '{50, 11, 1};
        tbl[2] = '{-128, 5, 1};
        tbl[3] = '{-3, 5, 0};
        tbl[4] = '{3, 11, 0};
        tbl[5] = '{-4, 5, 1};
        tbl[6] = '{4, 11, 1};
        tbl[7] = '{127, 11, 1};
        tbl[8] = '{0, 8, 0};

        rst = 1'b1;
        en = 1'b0;
        u_valid = 1'b0;
        u_k = '0;
        repeat (3) tick();
        chk("rst pwm_out", pwm_out, 0);
        chk("rst period_start", period_start, 0);
        chk("rst u_ack", u_ack, 0);
        chk("rst sat_flag", sat_flag, 0);
        chk("rst active_width", active_width, 8);

        // First edge after release with en high enters HIGH.
        rst = 1'b0;
        en = 1'b1;
        tick();
        chk("first period_start", period_start, 1);
        chk("first pwm_out", pwm_out, 1);
        chk("first u_ack", u_ack, 0);
        chk("first sat_flag", sat_flag, 0);

        run_period(-1, 0, -1, 0, -1, 0, hi, len, acks);
        chk("p1 high", hi, 8);
        chk("p1 len", len, 100);
        chk("p1 acks", acks, 0);
        chk("p2 u_ack", u_ack, 0);
        chk("p2 width", active_width, 8);
        cur_w = 8;

        // Table: sample mid-period leaves current period alone, next period adopts it.
        for (int i = 0; i < 9; i++) begin
            run_period(20, tbl[i].uk, -1, 0, -1, 0, hi, len, acks);
            chk($sformatf("v%0d cur high", i), hi, cur_w);
            chk($sformatf("v%0d len", i), len, 100);
            chk($sformatf("v%0d acks", i), acks, 0);
            chk($sformatf("v%0d width", i), active_width, tbl[i].w);
            chk($sformatf("v%0d sat", i), sat_flag, tbl[i].sat);
            chk($sformatf("v%0d u_ack", i), u_ack, 1);
            cur_w = tbl[i].w;
        end
        run_period(-1, 0, -1, 0, -1, 0, hi, len, acks);
        chk("tbl tail high", hi, cur_w);
        chk("tbl tail u_ack", u_ack, 0);

        // Sample coincident with the load edge is applied one period later.
        run_period(99, 1, -1, 0, -1, 0, hi, len, acks);
        chk("coin high", hi, 8);
        chk("coin B width", active_width, 8);
        chk("coin B u_ack", u_ack, 0);
        run_period(-1, 0, -1, 0, -1, 0, hi, len, acks);
        chk("coin B high", hi, 8);
        chk("coin C width", active_width, 9);
        chk("coin C u_ack", u_ack, 1);

        // Three samples in one period: last wins, single ack.
        run_period(10, 1, 20, 2, 30, -1, hi, len, acks);
        chk("three high", hi, 9);
        chk("three acks", acks, 0);
        chk("three width", active_width, 7);
        chk("three sat", sat_flag, 0);
        chk("three u_ack", u_ack, 1);
        run_period(-1, 0, -1, 0, -1, 0, hi, len, acks);
        chk("three next high", hi, 7);
        chk("three next acks", acks, 0);
        chk("three next u_ack", u_ack, 0);

        // en dropped mid-period: period completes, then stays idle.
        hi = 0;
        for (int c = 0; c < 100; c++) begin
            if (pwm_out) hi++;
            if (c == 40) en = 1'b0;
            tick();
        end
        hi2 = 0;
        ps_cnt = 0;
        for (int c = 0; c < 150; c++) begin
            if (pwm_out) hi2++;
            if (period_start) ps_cnt++;
            tick();
        end
        chk("endrop last high", hi, 7);
        chk("idle high", hi2, 0);
        chk("idle period_start", ps_cnt, 0);
        chk("idle width hold", active_width, 7);
        en = 1'b1;
        tick();
        chk("reen period_start", period_start, 1);
        chk("reen pwm_out", pwm_out, 1);
        chk("reen u_ack", u_ack, 0);
        run_period(-1, 0, -1, 0, -1, 0, hi, len, acks);
        chk("reen high", hi, 7);
        chk("reen len", len, 100);

        // Async reset during HIGH clears the output before the next edge.
        tick();
        tick();
        chk("pre-rst pwm_out", pwm_out, 1);
        rst = 1'b1;
        #1;
        chk("async rst pwm_out", pwm_out, 0);
        chk("async rst width", active_width, 8);
        chk("async rst sat", sat_flag, 0);
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("post-rst period_start", period_start, 1);
        run_period(-1, 0, -1, 0, -1, 0, hi, len, acks);
        chk("post-rst high", hi, 8);
        chk("post-rst len", len, 100);
        chk("post-rst acks", acks, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
